// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_unit_pkg
// Brief   : Shared FSM encoding, register width and M-field bit positions.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int REG_W_DEF = 5;

  // Layout of the 4-bit M control field latched by ID/EX
  localparam int M_W            = 4;
  localparam int M_BRANCH_BIT   = 3;
  localparam int M_MEMREAD_BIT  = 2;
  localparam int M_MEMWRITE_BIT = 1;
  localparam int M_JUMP_BIT     = 0;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational load-use compare between ID/EX load target and IF/ID sources.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_detect
  import hazard_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] rs_id_i,
  input  logic [REG_W-1:0] rt_id_i,
  input  logic             uses_rt_i,
  input  logic [REG_W-1:0] rt_ex_i,
  input  logic             mem_read_i,
  output logic             hz_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (rt_ex_i == rs_id_i);
  assign rt_match = uses_rt_i & (rt_ex_i == rt_id_i);
  // $0 is hard-wired, so a load into it never creates a dependency
  assign hz_o     = mem_read_i & (rt_ex_i != '0) & (rs_match | rt_match);

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_unit
// Brief   : Load-use stall / branch-jump flush controller. Optional counters
//           enabled by defining HAZARD_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_W             = REG_W_DEF
) (
  input  logic             clk_hazard_unit,
  input  logic             rst_hazard_unit,
  input  logic [REG_W-1:0] rs_ID_IN,
  input  logic [REG_W-1:0] rt_ID_IN,
  input  logic             usesRt_ID_IN,
  input  logic             jump_ID_IN,
  input  logic [REG_W-1:0] rt_EX_IN,
  input  logic             memRead_EX_IN,
  input  logic             branchTaken_MEM_IN,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             bubble_IDEX,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMEM,
  output logic             busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stallCount,
  output logic [15:0]      flushCount
`endif
);

  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] stall_cnt_q, stall_cnt_d;
  logic       hz;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .rs_id_i    (rs_ID_IN),
    .rt_id_i    (rt_ID_IN),
    .uses_rt_i  (usesRt_ID_IN),
    .rt_ex_i    (rt_EX_IN),
    .mem_read_i (memRead_EX_IN),
    .hz_o       (hz)
  );

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    bubble_IDEX = 1'b0;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_EXMEM = 1'b0;
    busy        = 1'b0;
    if (rst_hazard_unit) begin
      state_d     = RUN;
      stall_cnt_d = 4'd0;
    end else begin
      busy = (state_q != RUN);
      case (state_q)
        RUN: begin
          if (branchTaken_MEM_IN) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
            state_d     = FLUSH;
          end else if (hz) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            bubble_IDEX = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d     = STALL;
              stall_cnt_d = STALL_RELOAD;
            end
          end else if (jump_ID_IN) begin
            flush_IFID = 1'b1;
          end
        end
        STALL: begin
          // A taken branch squashes the stalled instruction anyway
          if (branchTaken_MEM_IN) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
            state_d     = FLUSH;
            stall_cnt_d = 4'd0;
          end else begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            bubble_IDEX = 1'b1;
            stall_cnt_d = stall_cnt_q - 4'd1;
            if (stall_cnt_q <= 4'd1) begin
              state_d     = RUN;
              stall_cnt_d = 4'd0;
            end
          end
        end
        FLUSH: begin
          flush_IFID = 1'b1;
          flush_IDEX = 1'b1;
          state_d    = RUN;
        end
        default: begin
          state_d     = RUN;
          stall_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_hazard_unit) begin
    if (rst_hazard_unit) begin
      state_q     <= RUN;
      stall_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_total_q;
  logic [15:0] flush_total_q;

  always_ff @(posedge clk_hazard_unit) begin
    if (rst_hazard_unit) begin
      stall_total_q <= 16'd0;
      flush_total_q <= 16'd0;
    end else begin
      if (bubble_IDEX && (stall_total_q != 16'hFFFF)) begin
        stall_total_q <= stall_total_q + 16'd1;
      end
      if (flush_EXMEM && (flush_total_q != 16'hFFFF)) begin
        flush_total_q <= flush_total_q + 16'd1;
      end
    end
  end

  assign stallCount = stall_total_q;
  assign flushCount = flush_total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_unit
// Brief   : Self-checking bench; two instances (1 and 3 stall cycles) vs. a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs, rt, rtex;
  logic       uses_rt, jmp, mem_rd, br;

  // Output vectors: {pcWrite, ifidWrite, bubble, flushIFID, flushIDEX, flushEXMEM, busy}
  logic [6:0] out1, out3;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, fc1, sc3, fc3;
`endif

  hazard_unit #(.LOAD_STALL_CYCLES(1), .REG_W(5)) dut1 (
    .clk_hazard_unit    (clk),
    .rst_hazard_unit    (rst),
    .rs_ID_IN           (rs),
    .rt_ID_IN           (rt),
    .usesRt_ID_IN       (uses_rt),
    .jump_ID_IN         (jmp),
    .rt_EX_IN           (rtex),
    .memRead_EX_IN      (mem_rd),
    .branchTaken_MEM_IN (br),
    .pcWrite            (out1[6]),
    .ifidWrite          (out1[5]),
    .bubble_IDEX        (out1[4]),
    .flush_IFID         (out1[3]),
    .flush_IDEX         (out1[2]),
    .flush_EXMEM        (out1[1]),
    .busy               (out1[0])
`ifdef HAZARD_STATS_EN
    ,
    .stallCount         (sc1),
    .flushCount         (fc1)
`endif
  );

  hazard_unit #(.LOAD_STALL_CYCLES(3), .REG_W(5)) dut3 (
    .clk_hazard_unit    (clk),
    .rst_hazard_unit    (rst),
    .rs_ID_IN           (rs),
    .rt_ID_IN           (rt),
    .usesRt_ID_IN       (uses_rt),
    .jump_ID_IN         (jmp),
    .rt_EX_IN           (rtex),
    .memRead_EX_IN      (mem_rd),
    .branchTaken_MEM_IN (br),
    .pcWrite            (out3[6]),
    .ifidWrite          (out3[5]),
    .bubble_IDEX        (out3[4]),
    .flush_IFID         (out3[3]),
    .flush_IDEX         (out3[2]),
    .flush_EXMEM        (out3[1]),
    .busy               (out3[0])
`ifdef HAZARD_STATS_EN
    ,
    .stallCount         (sc3),
    .flushCount         (fc3)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: extra bubble cycles still owed, and whether a post-branch flush cycle is due
  int left1 = 0, left3 = 0;
  bit fl1 = 0, fl3 = 0;
  int m_sc1 = 0, m_fc1 = 0, m_sc3 = 0, m_fc3 = 0;

  function automatic logic [6:0] exp_out(bit r, int left, bit fl, bit hz, bit b, bit j);
    if (r)        return 7'b1100000;
    if (fl)       return 7'b1101101;
    if (b)        return {6'b110111, (left > 0)};
    if (left > 0) return 7'b0010001;
    if (hz)       return 7'b0010000;
    if (j)        return 7'b1101000;
    return 7'b1100000;
  endfunction

  task automatic advance(input bit r, input bit hz, input bit b, input int stall_len,
                         inout int left, inout bit fl);
    if (r) begin
      left = 0; fl = 0;
    end else if (fl) begin
      fl = 0;
    end else if (b) begin
      fl = 1; left = 0;
    end else if (left > 0) begin
      left = left - 1;
    end else if (hz) begin
      left = stall_len - 1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input bit a_use, input bit a_jmp, input logic [4:0] a_rtex,
                      input bit a_mr, input bit a_br);
    bit hz;
    logic [6:0] e1, e3;
    @(negedge clk);
    rst = r; rs = a_rs; rt = a_rt; uses_rt = a_use; jmp = a_jmp;
    rtex = a_rtex; mem_rd = a_mr; br = a_br;
    #1;
    hz = a_mr && (a_rtex != 5'd0) && ((a_rtex == a_rs) || (a_use && (a_rtex == a_rt)));
    e1 = exp_out(r, left1, fl1, hz, a_br, a_jmp);
    e3 = exp_out(r, left3, fl3, hz, a_br, a_jmp);
    check("outs_L1", {9'd0, out1}, {9'd0, e1});
    check("outs_L3", {9'd0, out3}, {9'd0, e3});
`ifdef HAZARD_STATS_EN
    check("stall_cnt_L1", sc1, 16'(m_sc1));
    check("flush_cnt_L1", fc1, 16'(m_fc1));
    check("stall_cnt_L3", sc3, 16'(m_sc3));
    check("flush_cnt_L3", fc3, 16'(m_fc3));
`endif
    @(posedge clk);
    if (r) begin
      m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
    end else begin
      if (e1[4] && m_sc1 < 65535) m_sc1++;
      if (e1[1] && m_fc1 < 65535) m_fc1++;
      if (e3[4] && m_sc3 < 65535) m_sc3++;
      if (e3[1] && m_fc3 < 65535) m_fc3++;
    end
    advance(r, hz, a_br, 1, left1, fl1);
    advance(r, hz, a_br, 3, left3, fl3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0);
  endtask

  initial begin
    rst = 1'b1; rs = '0; rt = '0; rtex = '0;
    uses_rt = 1'b0; jmp = 1'b0; mem_rd = 1'b0; br = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // lw $5 followed by a reader of $5
    step(0, 5'd5, 5'd1, 0, 0, 5'd5, 1, 0);
    idle(3);

    // load into $0 never stalls
    step(0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);
    idle(1);

    // rt match only counts when rt is actually read
    step(0, 5'd2, 5'd7, 0, 0, 5'd7, 1, 0);
    step(0, 5'd2, 5'd7, 1, 0, 5'd7, 1, 0);
    idle(3);

    // branch taken during the multi-cycle stall
    step(0, 5'd4, 5'd1, 0, 0, 5'd4, 1, 0);
    step(0, 5'd4, 5'd1, 0, 0, 5'd4, 1, 1);
    step(0, 5'd4, 5'd1, 0, 0, 5'd4, 1, 0);
    idle(2);

    // jump alone, then jump losing to a load-use stall
    step(0, 5'd1, 5'd2, 0, 1, 5'd3, 0, 0);
    step(0, 5'd3, 5'd2, 0, 1, 5'd3, 1, 0);
    idle(3);

    // reset pulsed mid-stall
    step(0, 5'd6, 5'd1, 0, 0, 5'd6, 1, 0);
    step(1, 5'd6, 5'd1, 0, 0, 5'd6, 1, 0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      bit r_r, r_b;
      r_r = ($urandom_range(0, 39) == 0);
      r_b = !fl3 && ($urandom_range(0, 9) == 0);
      step(r_r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r_b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller; the consumer side of the ID/EX buffer interface.
- Reads the control and register fields that the ID/EX buffer latches, plus the IF/ID source fields.
- Decides stall (PC and IF/ID hold, bubble injected into ID/EX) and flush (IF/ID, ID/EX, EX/MEM cleared) each cycle.
- Contains a small FSM and counters to sequence multi-cycle load-use stalls and branch flushes.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (1..15).
- REG_W, 5, register-specifier width.

Ports:
- clk_hazard_unit  input  1  pipeline clock; all state updates on its rising edge.
- rst_hazard_unit  input  1  synchronous, active-high reset.
- rs_ID_IN  input  REG_W  rs field of the instruction in IF/ID.
- rt_ID_IN  input  REG_W  rt field of the instruction in IF/ID.
- usesRt_ID_IN  input  1  IF/ID instruction reads rt (R-type, beq, sw).
- jump_ID_IN  input  1  IF/ID instruction is a jump.
- rt_EX_IN  input  REG_W  rt latched in ID/EX (load destination).
- memRead_EX_IN  input  1  MemRead bit of the ID/EX M field.
- branchTaken_MEM_IN  input  1  branch resolved taken in EX/MEM.
- pcWrite  output  1  PC update enable.
- ifidWrite  output  1  IF/ID load enable.
- bubble_IDEX  output  1  forces ID/EX M/EX/WB control inputs to zero.
- flush_IFID  output  1  clears IF/ID.
- flush_IDEX  output  1  clears ID/EX.
- flush_EXMEM  output  1  clears EX/MEM.
- busy  output  1  FSM not in RUN.

Behaviour:
- FSM states: RUN, STALL, FLUSH. Reset forces RUN and stallCnt=0.
- Reset output values: pcWrite=1, ifidWrite=1, all other outputs 0.
- Outputs are combinational from state and current inputs (zero latency); state and counter are registered.
- Hazard detect: hz = memRead_EX_IN & (rt_EX_IN!=0) & ((rt_EX_IN==rs_ID_IN) | (usesRt_ID_IN & rt_EX_IN==rt_ID_IN)).
- RUN:
  - If branchTaken_MEM_IN: assert flush_IFID, flush_IDEX, flush_EXMEM for this cycle; next state FLUSH.
  - Else if hz: pcWrite=0, ifidWrite=0, bubble_IDEX=1. If LOAD_STALL_CYCLES>1, next state STALL with stallCnt=LOAD_STALL_CYCLES-1.
  - Else if jump_ID_IN: flush_IFID=1; stay in RUN.
- STALL:
  - pcWrite=0, ifidWrite=0, bubble_IDEX=1; stallCnt decrements each cycle.
  - When stallCnt reaches 1 on the clock edge, next state is RUN.
  - branchTaken_MEM_IN in STALL: flush overrides stall; all three flushes asserted, pcWrite=1, next state FLUSH, stallCnt cleared.
- FLUSH: one cycle with flush_IFID=1 and flush_IDEX=1, hazard detection suppressed (fetch is redirected); next state RUN.
- Priority order: reset > branch flush > load-use stall > jump flush.
- Register $0 never causes a hazard.
- Reset asserted mid-STALL or mid-FLUSH returns to RUN on the next edge; no residual bubble.
- busy=1 in STALL and FLUSH.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined: adds output ports stallCount[15:0] and flushCount[15:0].
  - stallCount increments on every cycle with bubble_IDEX=1.
  - flushCount increments on every cycle with flush_EXMEM=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds: FSM state encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2), the REG_W default, and localparam bit positions of MemRead within the 4-bit M field.
- Split out one sub-module, hazard_detect: purely combinational hz compare.
- The FSM and counters stay in hazard_unit.

Test Plan:
- lw $5 in ID/EX (memRead=1, rt_EX=5), IF/ID rs=5 -> same cycle pcWrite=0, ifidWrite=0, bubble_IDEX=1; next cycle all released (LOAD_STALL_CYCLES=1).
- memRead=1, rt_EX=0, rs_ID=0 -> no stall; pcWrite=1.
- rt_EX=7, rt_ID=7, usesRt=0 -> no stall; then usesRt=1 -> stall.
- LOAD_STALL_CYCLES=3, hazard at cycle 0 -> bubble_IDEX high cycles 0-2, busy high cycles 1-2, RUN at cycle 3.
- LOAD_STALL_CYCLES=3, branchTaken at cycle 1 of stall -> cycle 1 has all three flushes and pcWrite=1; cycle 2 flush_IFID=1 and flush_IDEX=1; cycle 3 RUN.
- Reset pulsed during STALL -> next cycle pcWrite=1, busy=0; with HAZARD_STATS_EN, counters read 0.
